// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add sequencer: state encoding
// and the nibble width of the external ripple adder.
package nibble_serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : nibble_serial_add_ctrl_pkg

// File: rtl/nibble_serial_add_ctrl.sv
// Sequences a WIDTH-bit addition through one shared external 4-bit adder,
// LSB nibble first, with the carry registered between nibbles.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;

    logic [NIBBLE_W-1:0] a_nib [NIBBLES];
    logic [NIBBLE_W-1:0] b_nib [NIBBLES];
    logic                run;
    logic                last_nib;

    // Operand latches viewed as nibble arrays so the mux index is just idx_q.
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign a_nib[gi] = a_q[gi*NIBBLE_W +: NIBBLE_W];
        assign b_nib[gi] = b_q[gi*NIBBLE_W +: NIBBLE_W];
    end

    assign run      = (state_q == ST_RUN);
    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

    // Adder inputs are held at zero outside RUN to keep the shared adder quiet.
    assign add_a   = run ? a_nib[idx_q] : '0;
    assign add_b   = run ? b_nib[idx_q] : '0;
    assign add_cin = run ? carry_q      : 1'b0;

    assign busy = run;
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*NIBBLE_W +: NIBBLE_W] = add_sum;
                    end
                end
                carry_d = add_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (last_nib) begin
                    cout_d  = add_cout;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

endmodule : nibble_serial_add_ctrl

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl; the shared 4-bit adder is
// modelled here and results are compared against plain a+b+cin arithmetic.
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // External shared adder: purely combinational 4-bit add with carry.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Launches one addition from an idle/done cycle (called 1 time unit after
    // a rising edge), checks every RUN cycle and the final result in the done
    // cycle, and returns still positioned in that done cycle.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tc, input string name);
        logic [WIDTH:0] expv;
        longint         mask;
        longint         partial;
        logic [3:0]     exp_na, exp_nb;
        logic           exp_c;
        expv  = {1'b0, ta} + {1'b0, tb_} + {{WIDTH{1'b0}}, tc};
        start = 1'b1;
        a     = ta;
        b     = tb_;
        cin   = tc;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
        for (int i = 0; i < NIBBLES; i++) begin
            mask    = (64'sd1 <<< (4 * i)) - 1;
            partial = (longint'(ta) & mask) + (longint'(tb_) & mask) + longint'(tc);
            exp_c   = 1'((partial >>> (4 * i)) & 1);
            exp_na  = 4'(ta >> (4 * i));
            exp_nb  = 4'(tb_ >> (4 * i));
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL %s run%0d busy/done: got %b/%b want 1/0", name, i, busy, done);
            end
            checks++;
            if (add_a !== exp_na || add_b !== exp_nb || add_cin !== exp_c) begin
                fails++;
                $display("FAIL %s run%0d add ports: got a=%h b=%h c=%b want a=%h b=%h c=%b",
                         name, i, add_a, add_b, add_cin, exp_na, exp_nb, exp_c);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s done cycle: got done=%b busy=%b want done=1 busy=0", name, done, busy);
        end
        checks++;
        if ({cout, sum} !== expv) begin
            fails++;
            $display("FAIL %s result: got cout=%b sum=%h want cout=%b sum=%h",
                     name, cout, sum, expv[WIDTH], expv[WIDTH-1:0]);
        end
        checks++;
        if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
            fails++;
            $display("FAIL %s add quiet in done: got a=%h b=%h c=%b want 0", name, add_a, add_b, add_cin);
        end
        $display("op %s: %h + %h + %b -> cout=%b sum=%h", name, ta, tb_, tc, cout, sum);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, cout, sum, add_a, add_b, add_cin} !== '0) begin
            fails++;
            $display("FAIL reset outputs: got busy=%b done=%b cout=%b sum=%h add=%h/%h/%b want all 0",
                     busy, done, cout, sum, add_a, add_b, add_cin);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done, cout, sum, add_a, add_b, add_cin} !== '0) begin
            fails++;
            $display("FAIL idle after reset: got busy=%b done=%b sum=%h want 0", busy, done, sum);
        end
        $display("reset: busy=%b done=%b sum=%h cout=%b", busy, done, sum, cout);
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [4] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hA5A5};
        logic [WIDTH-1:0] vb [4] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h5A5A};
        logic             vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            run_op(va[k], vb[k], vc[k], $sformatf("directed%0d", k));
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL directed%0d done pulse width: got done=%b busy=%b want 0/0", k, done, busy);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), $sformatf("random%0d", k));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_busy_ignore();
        int extra_done = 0;
        int extra_busy = 0;
        start = 1'b1;
        a     = 16'h0F0F;
        b     = 16'h0101;
        cin   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = 16'h1234;
        b     = 16'($urandom);
        cin   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || sum !== 16'h1010 || cout !== 1'b0) begin
            fails++;
            $display("FAIL busy_ignore result: got done=%b sum=%h cout=%b want done=1 sum=1010 cout=0",
                     done, sum, cout);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        checks++;
        if (extra_done != 0 || extra_busy != 0) begin
            fails++;
            $display("FAIL busy_ignore queued: got %0d extra done, %0d busy cycles want 0/0",
                     extra_done, extra_busy);
        end
        $display("busy_ignore: sum=%h cout=%b extra_done=%0d", sum, cout, extra_done);
    endtask

    task automatic test_rst_mid_run();
        int seen_done = 0;
        start = 1'b1;
        a     = 16'h9999;
        b     = 16'h9999;
        cin   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, cout, sum, add_a, add_b, add_cin} !== '0) begin
            fails++;
            $display("FAIL rst_mid_run async clear: got busy=%b done=%b cout=%b sum=%h want all 0",
                     busy, done, cout, sum);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NIBBLES + 3; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            fails++;
            $display("FAIL rst_mid_run aftermath: got %0d done/busy cycles want 0", seen_done);
        end
        run_op(16'h0007, 16'h0001, 1'b1, "after_rst");
        checks++;
        if (sum !== 16'h0009 || cout !== 1'b0) begin
            fails++;
            $display("FAIL after_rst value: got sum=%h cout=%b want 0009/0", sum, cout);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        run_op(16'($urandom), 16'($urandom), 1'($urandom), "b2b_first");
        // Still in the done cycle: the next request is accepted immediately.
        run_op(16'h8000, 16'h8000, 1'b0, "b2b_second");
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second value: got sum=%h cout=%b want 0000/1", sum, cout);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
            fails++;
            $display("FAIL b2b idle quiet: got done=%b add=%h/%h/%b want 0", done, add_a, add_b, add_cin);
        end
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b1) begin
            fails++;
            $display("FAIL b2b hold: got sum=%h cout=%b want 0000/1", sum, cout);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_rst_mid_run();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_nibble_serial_add_ctrl
